pool_cost_acc: RTL and testbench

- Downstream consumer of the pool-area stage.
- Takes each 17-bit area sample with a per-unit price over a valid/ready handshake.
- Computes cost = area × price with a sequential shift-add multiplier, one price bit per cycle.
- Presents each cost, and keeps a saturating running total of all costs since reset/clear for the reporting logic.

---
 rtl/pool_cost_pkg.sv | 15 +
 rtl/pool_seq_mul.sv | 51 +++++
 rtl/pool_cost_acc.sv | 105 ++++++++++
 tb/tb_pool_cost_acc.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/pool_cost_pkg.sv
// Shared widths, FSM encoding and counter sizing for the pool cost accumulator.
package pool_cost_pkg;
  localparam int DEF_AREA_W  = 17;
  localparam int DEF_PRICE_W = 8;
  localparam int DEF_COST_W  = DEF_AREA_W + DEF_PRICE_W;
  localparam int DEF_ACC_W   = 32;

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2} state_t;

  function automatic int cnt_w(input int pw);
    return $clog2(pw + 1);
  endfunction

  localparam int CNT_W = cnt_w(DEF_PRICE_W);
endpackage

// File: rtl/pool_seq_mul.sv
// Shift-add multiplier: one price bit per cycle, fixed PRICE_W iterations.
module pool_seq_mul import pool_cost_pkg::*; #(
  parameter int AREA_W  = DEF_AREA_W,
  parameter int PRICE_W = DEF_PRICE_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  input  logic [AREA_W-1:0]         i_area,
  input  logic [PRICE_W-1:0]        i_price,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [AREA_W+PRICE_W-1:0] o_prod_nxt
);
  localparam int COST_W = AREA_W + PRICE_W;
  localparam int CW     = cnt_w(PRICE_W);

  logic [COST_W-1:0]  r_mcand, r_prod;
  logic [PRICE_W-1:0] r_mplier;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic               w_last;

  // Product after this cycle's iteration; the top latches it on the final one.
  assign o_prod_nxt = r_prod + (r_mplier[0] ? r_mcand : '0);
  assign w_last     = r_busy && (r_cnt == CW'(PRICE_W - 1));
  assign o_busy     = r_busy;
  assign o_done     = w_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_mcand  <= COST_W'(i_area);
      r_mplier <= i_price;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_prod   <= o_prod_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (w_last) r_busy <= 1'b0;
    end
  end
endmodule

// File: rtl/pool_cost_acc.sv
// Area x price cost per sample, plus a saturating running total with sticky overflow.
module pool_cost_acc import pool_cost_pkg::*; #(
  parameter int AREA_W  = DEF_AREA_W,
  parameter int PRICE_W = DEF_PRICE_W,
  parameter int ACC_W   = DEF_ACC_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [AREA_W-1:0]         area,
  input  logic [PRICE_W-1:0]        price,
  input  logic                      clear,
  output logic                      cost_valid,
  output logic [AREA_W+PRICE_W-1:0] cost,
  output logic [ACC_W-1:0]          total,
  output logic                      total_ovf
);
  localparam int COST_W = AREA_W + PRICE_W;

  state_t            r_state, w_state_nxt;
  logic              w_start, w_accum, w_mul_busy, w_mul_done;
  logic [COST_W-1:0] w_prod_nxt, r_cost;
  logic              r_cost_valid;
  logic [ACC_W-1:0]  r_total;
  logic              r_ovf;
  logic [ACC_W:0]    w_sum;

  pool_seq_mul #(.AREA_W(AREA_W), .PRICE_W(PRICE_W)) u_mul (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_start),
    .i_area     (area),
    .i_price    (price),
    .o_busy     (w_mul_busy),
    .o_done     (w_mul_done),
    .o_prod_nxt (w_prod_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_accum     = 1'b0;
    in_ready    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = !w_mul_busy;
        if (in_valid && !w_mul_busy) begin
          w_start     = 1'b1;
          w_state_nxt = MUL;
        end
      end
      MUL:  if (w_mul_done) w_state_nxt = DONE;
      DONE: begin
        w_accum     = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // One extra bit catches the carry that drives saturation.
  assign w_sum = {1'b0, r_total} + {{(ACC_W + 1 - COST_W){1'b0}}, r_cost};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cost       <= '0;
      r_cost_valid <= 1'b0;
    end else begin
      r_cost_valid <= 1'b0;
      if (r_state == MUL && w_mul_done) begin
        r_cost       <= w_prod_nxt;
        r_cost_valid <= 1'b1;
      end
    end
  end

  // clear outranks the DONE-edge accumulate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_total <= '0;
      r_ovf   <= 1'b0;
    end else if (clear) begin
      r_total <= '0;
      r_ovf   <= 1'b0;
    end else if (w_accum) begin
      if (w_sum[ACC_W]) begin
        r_total <= '1;
        r_ovf   <= 1'b1;
      end else begin
        r_total <= w_sum[ACC_W-1:0];
      end
    end
  end

  assign cost_valid = r_cost_valid;
  assign cost       = r_cost;
  assign total      = r_total;
  assign total_ovf  = r_ovf;
endmodule

// File: tb/tb_pool_cost_acc.sv
// Directed bench for pool_cost_acc: timing, extremes, back-to-back, clear, reset, saturation.
module tb_pool_cost_acc;
  logic        clk, rst, in_valid, clear, in_ready, cost_valid, total_ovf;
  logic [16:0] area;
  logic [7:0]  price;
  logic [24:0] cost;
  logic [31:0] total;
  logic        in_valid_s, clear_s, in_ready_s, cost_valid_s, ovf_s;
  logic [24:0] cost_s, total_s;
  int checks = 0;
  int errors = 0;

  pool_cost_acc u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .area(area), .price(price), .clear(clear), .cost_valid(cost_valid),
    .cost(cost), .total(total), .total_ovf(total_ovf)
  );

  pool_cost_acc #(.ACC_W(25)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .area(area), .price(price), .clear(clear_s), .cost_valid(cost_valid_s),
    .cost(cost_s), .total(total_s), .total_ovf(ovf_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  // Drives one pair from IDLE and watches 12 cycles for strobes.
  task automatic run_txn(input logic [16:0] a, input logic [7:0] p,
                         output logic [24:0] c, output int nstrobe);
    area = a; price = p; in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    nstrobe = 0; c = 'x;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (cost_valid) begin nstrobe++; c = cost; end
    end
  endtask

  task automatic run_sat(input logic [16:0] a, input logic [7:0] p);
    area = a; price = p; in_valid_s = 1'b1;
    tick(); in_valid_s = 1'b0;
    repeat (12) tick();
  endtask

  task automatic test_reset();
    #2;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (cost_valid !== 1'b0) begin errors++; $display("FAIL reset_cost_valid got %b exp 0", cost_valid); end
    checks++; if (cost !== 25'd0) begin errors++; $display("FAIL reset_cost got %0d exp 0", cost); end
    checks++; if (total !== 32'd0) begin errors++; $display("FAIL reset_total got %0d exp 0", total); end
    checks++; if (total_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", total_ovf); end
    checks++; if (total_s !== 25'd0) begin errors++; $display("FAIL reset_total_s got %0d exp 0", total_s); end
    @(posedge clk); #1; rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    area = 17'd100; price = 8'd3; in_valid = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_pre got %b exp 1", in_ready); end
    tick(); in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) tick();
      checks++;
      if (in_ready !== (k == 9)) begin errors++; $display("FAIL basic_in_ready k=%0d got %b exp %b", k, in_ready, (k == 9)); end
      checks++;
      if (cost_valid !== (k == 8)) begin errors++; $display("FAIL basic_cost_valid k=%0d got %b exp %b", k, cost_valid, (k == 8)); end
      if (k == 8) begin
        checks++; if (cost !== 25'd300) begin errors++; $display("FAIL basic_cost got %0d exp 300", cost); end
      end
    end
    checks++; if (total !== 32'd300) begin errors++; $display("FAIL basic_total got %0d exp 300", total); end
  endtask

  task automatic test_extremes();
    logic [24:0] c; int n;
    pulse_clear();
    checks++; if (total !== 32'd0) begin errors++; $display("FAIL clear_total got %0d exp 0", total); end
    run_txn(17'd131071, 8'd255, c, n);
    checks++; if (c !== 25'd33423105) begin errors++; $display("FAIL max_cost got %0d exp 33423105", c); end
    checks++; if (n != 1) begin errors++; $display("FAIL max_strobes got %0d exp 1", n); end
    checks++; if (total !== 32'd33423105) begin errors++; $display("FAIL max_total got %0d exp 33423105", total); end
    run_txn(17'd0, 8'd200, c, n);
    checks++; if (c !== 25'd0) begin errors++; $display("FAIL zero_cost got %0d exp 0", c); end
    checks++; if (n != 1) begin errors++; $display("FAIL zero_strobes got %0d exp 1", n); end
    checks++; if (total !== 32'd33423105) begin errors++; $display("FAIL zero_total got %0d exp 33423105", total); end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int at[4];
    logic [24:0] cv[4];
    pulse_clear();
    area = 17'd5; price = 8'd7; in_valid = 1'b1;
    tick();
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (k == 4) begin area = 17'd9; price = 8'd9; end
      if (k == 12) in_valid = 1'b0;
      if (cost_valid && n < 4) begin at[n] = k; cv[n] = cost; n++; end
    end
    checks++; if (n != 2) begin errors++; $display("FAIL b2b_strobes got %0d exp 2", n); end
    if (n >= 2) begin
      checks++; if (at[0] != 8 || cv[0] !== 25'd35) begin errors++; $display("FAIL b2b_first got cyc %0d cost %0d exp cyc 8 cost 35", at[0], cv[0]); end
      checks++; if (at[1] != 18 || cv[1] !== 25'd81) begin errors++; $display("FAIL b2b_second got cyc %0d cost %0d exp cyc 18 cost 81", at[1], cv[1]); end
    end
    checks++; if (total !== 32'd116) begin errors++; $display("FAIL b2b_total got %0d exp 116", total); end
  endtask

  task automatic test_clear_on_done();
    logic [24:0] c; int n;
    pulse_clear();
    run_txn(17'd5, 8'd10, c, n);
    checks++; if (total !== 32'd50) begin errors++; $display("FAIL cod_pre_total got %0d exp 50", total); end
    area = 17'd10; price = 8'd10; in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    repeat (8) tick();
    checks++; if (cost_valid !== 1'b1 || cost !== 25'd100) begin errors++; $display("FAIL cod_strobe got v=%b cost=%0d exp v=1 cost=100", cost_valid, cost); end
    clear = 1'b1; tick(); clear = 1'b0;
    checks++; if (total !== 32'd0) begin errors++; $display("FAIL cod_total got %0d exp 0", total); end
    checks++; if (total_ovf !== 1'b0) begin errors++; $display("FAIL cod_ovf got %b exp 0", total_ovf); end
    checks++; if (cost !== 25'd100 || cost_valid !== 1'b0) begin errors++; $display("FAIL cod_hold got v=%b cost=%0d exp v=0 cost=100", cost_valid, cost); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL cod_ready got %b exp 1", in_ready); end
    tick();
  endtask

  task automatic test_reset_mid_mul();
    logic [24:0] c; int n; int seen = 0;
    run_txn(17'd3, 8'd3, c, n);
    checks++; if (total !== 32'd9) begin errors++; $display("FAIL rmm_pre_total got %0d exp 9", total); end
    area = 17'd20; price = 8'd20; in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b0; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmm_ready got %b exp 1", in_ready); end
    checks++; if (cost_valid !== 1'b0 || cost !== 25'd0) begin errors++; $display("FAIL rmm_cost got v=%b cost=%0d exp v=0 cost=0", cost_valid, cost); end
    checks++; if (total !== 32'd0 || total_ovf !== 1'b0) begin errors++; $display("FAIL rmm_total got %0d ovf %b exp 0 0", total, total_ovf); end
    @(posedge clk); #1; rst = 1'b1;
    repeat (12) begin tick(); if (cost_valid) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL rmm_no_strobe got %0d exp 0", seen); end
    run_txn(17'd2, 8'd2, c, n);
    checks++; if (c !== 25'd4 || n != 1) begin errors++; $display("FAIL rmm_next got cost %0d strobes %0d exp 4 1", c, n); end
    checks++; if (total !== 32'd4) begin errors++; $display("FAIL rmm_next_total got %0d exp 4", total); end
  endtask

  task automatic test_saturation();
    run_sat(17'd131071, 8'd255);
    checks++; if (total_s !== 25'd33423105 || ovf_s !== 1'b0) begin errors++; $display("FAIL sat_first got %0d ovf %b exp 33423105 0", total_s, ovf_s); end
    run_sat(17'd131071, 8'd255);
    checks++; if (total_s !== 25'd33554431 || ovf_s !== 1'b1) begin errors++; $display("FAIL sat_second got %0d ovf %b exp 33554431 1", total_s, ovf_s); end
    run_sat(17'd1, 8'd1);
    checks++; if (total_s !== 25'd33554431 || ovf_s !== 1'b1) begin errors++; $display("FAIL sat_third got %0d ovf %b exp 33554431 1", total_s, ovf_s); end
    checks++; if (cost_s !== 25'd1) begin errors++; $display("FAIL sat_third_cost got %0d exp 1", cost_s); end
    clear_s = 1'b1; tick(); clear_s = 1'b0;
    checks++; if (total_s !== 25'd0 || ovf_s !== 1'b0) begin errors++; $display("FAIL sat_clear got %0d ovf %b exp 0 0", total_s, ovf_s); end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; clear = 1'b0; area = '0; price = '0;
    in_valid_s = 1'b0; clear_s = 1'b0;
    test_reset();
    test_basic();
    test_extremes();
    test_back_to_back();
    test_clear_on_done();
    test_saturation();
    test_reset_mid_mul();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
